// File: rtl/mc6809_clkgen_pkg.sv
// Shared phase-index helpers, event type and width function for the E/Q clock generator.
package mc6809_clk_pkg;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_Q_RISE,
    EV_E_RISE,
    EV_Q_FALL,
    EV_E_FALL
  } clk_event_e;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned q_rise_ph(input int unsigned div);
    return div / 4;
  endfunction

  function automatic int unsigned e_rise_ph(input int unsigned div);
    return div / 2;
  endfunction

  function automatic int unsigned q_fall_ph(input int unsigned div);
    return (3 * div) / 4;
  endfunction

  function automatic int unsigned e_fall_ph(input int unsigned div);
    return (div == 0) ? 0 : 0;
  endfunction

  // Event issued on the edge that moves the counter to phase ph.
  function automatic clk_event_e phase_event(input int unsigned ph, input int unsigned div);
    if (ph == e_fall_ph(div))      return EV_E_FALL;
    else if (ph == q_rise_ph(div)) return EV_Q_RISE;
    else if (ph == e_rise_ph(div)) return EV_E_RISE;
    else if (ph == q_fall_ph(div)) return EV_Q_FALL;
    else                           return EV_NONE;
  endfunction

endpackage

// File: rtl/mc6809_clkgen_if.sv
// Clock-generator output bundle: E/Q, phase enables, core reset, phase index and MRDY.
interface mc6809_clkgen_if
  import mc6809_clk_pkg::*;
#(
  parameter int unsigned DIV = 4
);
  logic                          MRDY;
  logic                          E;
  logic                          Q;
  logic                          CE_E_RISE;
  logic                          CE_E_FALL;
  logic                          CE_Q_RISE;
  logic                          CE_Q_FALL;
  logic                          nCoreRESET;
  logic [clog2_min1(DIV)-1:0]    PHASE;

  modport master (
    input  MRDY,
    output E, Q, CE_E_RISE, CE_E_FALL, CE_Q_RISE, CE_Q_FALL, nCoreRESET, PHASE
  );

  modport slave (
    output MRDY,
    input  E, Q, CE_E_RISE, CE_E_FALL, CE_Q_RISE, CE_Q_FALL, nCoreRESET, PHASE
  );
endinterface

// File: rtl/mc6809_clkgen_rst_release.sv
// Saturating count of Q falls after reset; raises nCoreRESET on the final one and holds it.
module mc6809_rst_release
  import mc6809_clk_pkg::*;
#(
  parameter int unsigned RESET_RELEASE_CYCLES = 1
) (
  input  logic clk,
  input  logic RESET,
  input  logic qFallIssue,
  output logic nCoreRESET
);
  localparam int unsigned CW = clog2_min1(RESET_RELEASE_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(RESET_RELEASE_CYCLES);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (RESET) begin
      cnt        <= '0;
      nCoreRESET <= 1'b0;
    end else if (qFallIssue && cnt != LIMIT) begin
      cnt <= cnt + CW'(1);
      if (cnt == LIMIT - CW'(1)) nCoreRESET <= 1'b1;
    end
  end
endmodule

// File: rtl/mc6809_clkgen.sv
// E/Q quadrature clock and phase-enable generator dividing CLK_ROOT by DIV.
// Optional MRDY E-stretch: define MC6809_MRDY_STRETCH_EN.
module mc6809_clkgen
  import mc6809_clk_pkg::*;
#(
  parameter int unsigned DIV                  = 4,
  parameter int unsigned RESET_RELEASE_CYCLES = 1
) (
  input  logic                CLK_ROOT,
  input  logic                RESET,
  mc6809_clkgen_if.master     bus
);
  localparam int unsigned PW = clog2_min1(DIV);
  localparam logic [PW-1:0] LAST_PH   = PW'(DIV - 1);
  localparam logic [PW-1:0] Q_RISE_PH = PW'(q_rise_ph(DIV));
  localparam logic [PW-1:0] E_RISE_PH = PW'(e_rise_ph(DIV));
  localparam logic [PW-1:0] Q_FALL_PH = PW'(q_fall_ph(DIV));
  localparam logic [PW-1:0] E_FALL_PH = PW'(e_fall_ph(DIV));

  if (DIV < 4 || (DIV % 4) != 0) begin : g_bad_div
    $error("mc6809_clkgen: DIV must be a multiple of 4 and at least 4");
  end
  if (RESET_RELEASE_CYCLES < 1) begin : g_bad_rrc
    $error("mc6809_clkgen: RESET_RELEASE_CYCLES must be at least 1");
  end

  logic [PW-1:0] phase;
  logic [PW-1:0] nxt;
  logic          stall;
  logic          e, q;
  logic          ceER, ceEF, ceQR, ceQF;
  logic          qFallIssue;
  clk_event_e    ev;

  always_comb begin
    nxt = (phase == LAST_PH) ? '0 : phase + PW'(1);
    ev  = phase_event(32'(nxt), DIV);
`ifdef MC6809_MRDY_STRETCH_EN
    stall = (phase == Q_FALL_PH - PW'(1)) && !bus.MRDY;
`else
    // MRDY has no effect in this build; read so the port is not dangling.
    stall = bus.MRDY & 1'b0;
`endif
    qFallIssue = !RESET && !stall && (ev == EV_Q_FALL);
  end

  always_ff @(posedge CLK_ROOT) begin
    if (RESET) begin
      phase <= '0;
      e     <= 1'b0;
      q     <= 1'b0;
      ceER  <= 1'b0;
      ceEF  <= 1'b0;
      ceQR  <= 1'b0;
      ceQF  <= 1'b0;
    end else if (stall) begin
      ceER <= 1'b0;
      ceEF <= 1'b0;
      ceQR <= 1'b0;
      ceQF <= 1'b0;
    end else begin
      phase <= nxt;
      ceER  <= (ev == EV_E_RISE);
      ceEF  <= (ev == EV_E_FALL);
      ceQR  <= (ev == EV_Q_RISE);
      ceQF  <= (ev == EV_Q_FALL);
      case (ev)
        EV_Q_RISE: q <= 1'b1;
        EV_E_RISE: e <= 1'b1;
        EV_Q_FALL: q <= 1'b0;
        EV_E_FALL: e <= 1'b0;
        default:   ;
      endcase
    end
  end

  mc6809_rst_release #(
    .RESET_RELEASE_CYCLES(RESET_RELEASE_CYCLES)
  ) u_rst_release (
    .clk       (CLK_ROOT),
    .RESET     (RESET),
    .qFallIssue(qFallIssue),
    .nCoreRESET(bus.nCoreRESET)
  );

  assign bus.PHASE     = phase;
  assign bus.E         = e;
  assign bus.Q         = q;
  assign bus.CE_E_RISE = ceER;
  assign bus.CE_E_FALL = ceEF;
  assign bus.CE_Q_RISE = ceQR;
  assign bus.CE_Q_FALL = ceQF;

  // Unused localparams kept for readability of the phase map.
  logic unusedPh;
  assign unusedPh = ^{Q_RISE_PH, E_RISE_PH, E_FALL_PH};
endmodule

// File: tb/tb_mc6809_clkgen.sv
// Randomised check of three clkgen builds against an arithmetic phase model, plus pinned waveform points.
module tb_mc6809_clkgen;
  import mc6809_clk_pkg::*;

  logic clk;
  logic rst;
  logic mrdy;
  int   checks   = 0;
  int   failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mc6809_clkgen_if #(.DIV(4)) if4  ();
  mc6809_clkgen_if #(.DIV(8)) if8  ();
  mc6809_clkgen_if #(.DIV(4)) if4r ();

  assign if4.MRDY  = mrdy;
  assign if8.MRDY  = mrdy;
  assign if4r.MRDY = mrdy;

  mc6809_clkgen #(.DIV(4), .RESET_RELEASE_CYCLES(1)) u_d4  (.CLK_ROOT(clk), .RESET(rst), .bus(if4));
  mc6809_clkgen #(.DIV(8), .RESET_RELEASE_CYCLES(2)) u_d8  (.CLK_ROOT(clk), .RESET(rst), .bus(if8));
  mc6809_clkgen #(.DIV(4), .RESET_RELEASE_CYCLES(3)) u_d4r (.CLK_ROOT(clk), .RESET(rst), .bus(if4r));

  int   oPh [3];
  logic oE [3], oQ [3], oER [3], oEF [3], oQR [3], oQF [3], oRst [3];

  assign oPh[0] = int'(if4.PHASE);  assign oPh[1] = int'(if8.PHASE);  assign oPh[2] = int'(if4r.PHASE);
  assign oE[0]  = if4.E;            assign oE[1]  = if8.E;            assign oE[2]  = if4r.E;
  assign oQ[0]  = if4.Q;            assign oQ[1]  = if8.Q;            assign oQ[2]  = if4r.Q;
  assign oER[0] = if4.CE_E_RISE;    assign oER[1] = if8.CE_E_RISE;    assign oER[2] = if4r.CE_E_RISE;
  assign oEF[0] = if4.CE_E_FALL;    assign oEF[1] = if8.CE_E_FALL;    assign oEF[2] = if4r.CE_E_FALL;
  assign oQR[0] = if4.CE_Q_RISE;    assign oQR[1] = if8.CE_Q_RISE;    assign oQR[2] = if4r.CE_Q_RISE;
  assign oQF[0] = if4.CE_Q_FALL;    assign oQF[1] = if8.CE_Q_FALL;    assign oQF[2] = if4r.CE_Q_FALL;
  assign oRst[0] = if4.nCoreRESET;  assign oRst[1] = if8.nCoreRESET;  assign oRst[2] = if4r.nCoreRESET;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: phase = active cycles since reset mod DIV; outputs follow from the quarter it lies in.
  int unsigned divs [3] = '{4, 8, 4};
  int unsigned rrcs [3] = '{1, 2, 3};
  int unsigned mPh  [3];
  int unsigned mQf  [3];
  bit          mAdv [3];
  bit          modelValid = 1'b0;
`ifdef MC6809_MRDY_STRETCH_EN
  localparam bit STRETCH = 1'b1;
`else
  localparam bit STRETCH = 1'b0;
`endif

  always @(posedge clk) begin
    if (rst) modelValid <= 1'b1;
    for (int i = 0; i < 3; i++) begin
      int unsigned qt;
      qt = divs[i] / 4;
      if (rst) begin
        mPh[i] = 0; mQf[i] = 0; mAdv[i] = 1'b0;
      end else if (STRETCH && mPh[i] == 3 * qt - 1 && !mrdy) begin
        mAdv[i] = 1'b0;
      end else begin
        mPh[i]  = (mPh[i] + 1) % divs[i];
        mAdv[i] = 1'b1;
        if (mPh[i] == 3 * qt) mQf[i]++;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (modelValid) begin
      for (int i = 0; i < 3; i++) begin
        int unsigned qt, p;
        qt = divs[i] / 4;
        p  = mPh[i];
        check($sformatf("PHASE[%0d]", i), oPh[i], int'(p));
        check($sformatf("E[%0d]", i), int'(oE[i]), int'(p >= 2 * qt));
        check($sformatf("Q[%0d]", i), int'(oQ[i]), int'(p >= qt && p < 3 * qt));
        check($sformatf("CE_Q_RISE[%0d]", i), int'(oQR[i]), int'(mAdv[i] && p == qt));
        check($sformatf("CE_E_RISE[%0d]", i), int'(oER[i]), int'(mAdv[i] && p == 2 * qt));
        check($sformatf("CE_Q_FALL[%0d]", i), int'(oQF[i]), int'(mAdv[i] && p == 3 * qt));
        check($sformatf("CE_E_FALL[%0d]", i), int'(oEF[i]), int'(mAdv[i] && p == 0));
        check($sformatf("nCoreRESET[%0d]", i), int'(oRst[i]), int'(mQf[i] >= rrcs[i]));
      end
    end
  end

  initial begin
    int tries;
    rst  = 1'b1;
    mrdy = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_PHASE", oPh[0], 0);
    check("rst_nCoreRESET", int'(oRst[0]), 0);
    rst = 1'b0;

    // Pinned waveform points, clock k = k-th edge after RESET drops.
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (k <= 5) check($sformatf("lit_d4_phase_clk%0d", k), oPh[0], k % 4);
      if (k == 1) begin check("lit_d4_Q_clk1", int'(oQ[0]), 1); check("lit_d4_E_clk1", int'(oE[0]), 0); end
      if (k == 2) begin check("lit_d4_E_clk2", int'(oE[0]), 1); check("lit_d4_nrst_clk2", int'(oRst[0]), 0); end
      if (k == 3) begin check("lit_d4_qfall_clk3", int'(oQF[0]), 1); check("lit_d4_nrst_clk3", int'(oRst[0]), 1); end
      if (k == 2) check("lit_d8_qrise_clk2", int'(oQR[1]), 1);
      if (k == 4) check("lit_d8_erise_clk4", int'(oER[1]), 1);
      if (k == 6) check("lit_d8_qfall_clk6", int'(oQF[1]), 1);
      if (k == 8) begin check("lit_d8_efall_clk8", int'(oEF[1]), 1); check("lit_d8_phase_clk8", oPh[1], 0); end
      if (k == 10) check("lit_r3_nrst_clk10", int'(oRst[2]), 0);
      if (k == 11) check("lit_r3_nrst_clk11", int'(oRst[2]), 1);
    end

    // Reset mid-cycle with E high.
    tries = 0;
    @(negedge clk);
    while (oPh[0] != 2 && tries < 16) begin
      @(negedge clk);
      tries++;
    end
    check("wait_phase2_bound", int'(oPh[0] == 2), 1);
    check("mid_E_before", int'(oE[0]), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_E", int'(oE[0]), 0);
    check("mid_Q", int'(oQ[0]), 0);
    check("mid_ce_any", int'(oER[0] | oEF[0] | oQR[0] | oQF[0]), 0);
    check("mid_nrst", int'(oRst[0]), 0);
    @(negedge clk);
    rst = 1'b0;

    repeat (4000) begin
      @(negedge clk);
      rst  = ($urandom_range(0, 99) == 0);
      mrdy = ($urandom_range(0, 2) != 0);
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
